// File: rtl/mem_pkg.sv
// Shared types for the memAction-to-RAM read-modify-write bridge:
// request layout, controller states and word geometry.
package mem_pkg;

    localparam int WORD_BYTES = 32'sd8;

    typedef struct packed {
        logic                    wren;
        logic [WORD_BYTES-1:0]   mask;
        logic [63:0]             addr;
        logic [63:0]             data;
    } mem_req_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Word accesses only; any set low address bit is a misaligned request.
    function automatic logic word_aligned(input logic [63:0] addr);
        return (addr[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational byte lane merge: each set mask bit takes the new byte,
// each clear bit keeps the old byte.
module byte_merge
    import mem_pkg::*;
(
    input  logic [63:0] old_i,
    input  logic [63:0] new_i,
    input  logic [7:0]  mask_i,
    output logic [63:0] merged_o
);

    // Per-lane select between stored and incoming byte.
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (mask_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end else begin
                merged_o[8*i +: 8] = old_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_rmw_bridge_chk.sv
// Protocol properties of the bridge outputs: RAM strobes exclusive, idle
// address parked at zero, response held stable while back-pressured.
module mem_rmw_bridge_chk (
    input logic        clk,
    input logic        reset,
    input logic        ram_rden,
    input logic        ram_wren,
    input logic [63:0] ram_addr,
    input logic        resp_valid,
    input logic        resp_ready,
    input logic [63:0] resp_data,
    input logic        resp_err
);

    logic        hold_q;
    logic [63:0] data_q;
    logic        err_q;

    // Remember the response presented in a cycle that did not complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= 1'b0;
            data_q <= 64'h0;
            err_q  <= 1'b0;
        end else begin
            hold_q <= resp_valid && !resp_ready;
            data_q <= resp_data;
            err_q  <= resp_err;
        end
    end

    a_strobe_excl: assert property (@(posedge clk) !(ram_rden && ram_wren));
    a_addr_parked: assert property (@(posedge clk) (ram_rden || ram_wren || (ram_addr == 64'h0)));
    a_resp_stable: assert property (@(posedge clk) disable iff (reset)
        hold_q |-> (resp_valid && (resp_data == data_q) && (resp_err == err_q)));

endmodule

// File: rtl/mem_rmw_bridge.sv
// Bridge from the processor memAction port (byte-masked word requests) to a
// full-word RAM port, doing read-modify-write for partial stores.
module mem_rmw_bridge
    import mem_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [136:0] req,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [63:0]  resp_data,
    output logic         resp_err,
    output logic [63:0]  ram_addr,
    output logic         ram_rden,
    output logic         ram_wren,
    output logic [63:0]  ram_wdata,
    input  logic [63:0]  ram_rdata,
    input  logic         ram_exception
);

    state_t      state_q;
    mem_req_t    req_q;
    mem_req_t    req_s;
    logic [63:0] word_q;
    logic [63:0] merged_s;
    logic [63:0] resp_data_q;
    logic        resp_err_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        ram_rden_q;
    logic        ram_wren_q;
    logic [63:0] ram_addr_q;
    logic [63:0] ram_wdata_q;

    assign req_s = mem_req_t'(req);

    byte_merge u_merge (
        .old_i    (ram_rdata),
        .new_i    (req_q.data),
        .mask_i   (req_q.mask),
        .merged_o (merged_s)
    );

    // Controller: every output flop is loaded with its value for the state being entered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            req_q        <= '0;
            word_q       <= 64'h0;
            resp_data_q  <= 64'h0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            ram_rden_q   <= 1'b0;
            ram_wren_q   <= 1'b0;
            ram_addr_q   <= 64'h0;
            ram_wdata_q  <= 64'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_q       <= req_s;
                        req_ready_q <= 1'b0;
                        resp_data_q <= 64'h0;
                        if (!word_aligned(req_s.addr)) begin
                            resp_err_q   <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (req_s.wren && (req_s.mask == 8'h00)) begin
                            resp_err_q   <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else if (req_s.wren && (req_s.mask == 8'hFF)) begin
                            // Whole-word store needs no read of the old contents.
                            resp_err_q  <= 1'b0;
                            word_q      <= req_s.data;
                            ram_wren_q  <= 1'b1;
                            ram_addr_q  <= req_s.addr;
                            ram_wdata_q <= req_s.data;
                            state_q     <= WRITE;
                        end else begin
                            resp_err_q <= 1'b0;
                            ram_rden_q <= 1'b1;
                            ram_addr_q <= req_s.addr;
                            state_q    <= READ;
                        end
                    end
                end
                READ: begin
                    ram_rden_q <= 1'b0;
                    ram_addr_q <= 64'h0;
                    state_q    <= MERGE;
                end
                MERGE: begin
                    if (ram_exception) begin
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= 64'h0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (!req_q.wren) begin
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= ram_rdata;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        // Partial store answers with the word as it was before the store.
                        resp_err_q  <= 1'b0;
                        resp_data_q <= ram_rdata;
                        word_q      <= merged_s;
                        ram_wren_q  <= 1'b1;
                        ram_addr_q  <= req_q.addr;
                        ram_wdata_q <= merged_s;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    ram_wren_q   <= 1'b0;
                    ram_addr_q   <= 64'h0;
                    ram_wdata_q  <= 64'h0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    ram_rden_q   <= 1'b0;
                    ram_wren_q   <= 1'b0;
                    ram_addr_q   <= 64'h0;
                    ram_wdata_q  <= 64'h0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign ram_rden   = ram_rden_q;
    assign ram_wren   = ram_wren_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

    mem_rmw_bridge_chk u_chk (
        .clk        (CLK),
        .reset      (RESET),
        .ram_rden   (ram_rden),
        .ram_wren   (ram_wren),
        .ram_addr   (ram_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

endmodule

// File: tb/tb_mem_rmw_bridge.sv
// Bench for mem_rmw_bridge: RAM model, transaction-level reference model,
// per-cycle compare, directed literal cases and random traffic.
module tb_mem_rmw_bridge;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         req_valid;
    logic         req_ready;
    logic [136:0] req_bits;
    logic         resp_valid;
    logic         resp_ready;
    logic [63:0]  resp_data;
    logic         resp_err;
    logic [63:0]  ram_addr;
    logic         ram_rden;
    logic         ram_wren;
    logic [63:0]  ram_wdata;
    logic [63:0]  ram_rdata = 64'h0;
    logic         ram_exception = 1'b0;

    mem_rmw_bridge dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready), .req(req_bits),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_exception(ram_exception)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // RAM environment: 64 words, read data and exception one cycle after rden.
    logic [63:0] preload [64];
    logic [63:0] ram_mem [64];
    bit          exc_plan = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= preload[i];
        end else if (ram_wren) begin
            ram_mem[ram_addr[8:3]] <= ram_wdata;
        end
        ram_rdata     <= ram_rden ? ram_mem[ram_addr[8:3]] : 64'h0;
        ram_exception <= ram_rden && exc_plan;
        rd_cnt        <= rd_cnt + (ram_rden ? 1 : 0);
        wr_cnt        <= wr_cnt + (ram_wren ? 1 : 0);
    end

    // Reference model: outcome of one transaction straight from the request.
    typedef struct {
        int          lat;
        bit          rd;
        int          wr_cyc;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic [63:0] model_mem [64];
    exp_t        ex;
    bit          busy = 1'b0;
    bit          started = 1'b0;
    int          cyc = 0;

    function automatic exp_t predict(input logic [136:0] r, input bit exc);
        exp_t        p;
        logic        w    = r[136];
        logic [7:0]  m    = r[135:128];
        logic [63:0] a    = r[127:64];
        logic [63:0] d    = r[63:0];
        logic [63:0] old  = model_mem[a[8:3]];
        logic [63:0] bm   = 64'h0;
        p.lat = 0; p.rd = 1'b0; p.wr_cyc = 0; p.addr = a;
        p.wdata = 64'h0; p.data = 64'h0; p.err = 1'b0;
        for (int b = 0; b < 8; b++) if (m[b]) bm = bm | (64'hFF << (8 * b));
        if (a % 64'd8 != 64'd0) begin
            p.lat = 1; p.err = 1'b1;
        end else if (w && m == 8'h00) begin
            p.lat = 1;
        end else if (w && m == 8'hFF) begin
            p.lat = 2; p.wr_cyc = 1; p.wdata = d;
        end else begin
            p.rd = 1'b1; p.lat = 3;
            if (exc) p.err = 1'b1;
            else if (!w) p.data = old;
            else begin
                p.lat = 4; p.wr_cyc = 3; p.data = old;
                p.wdata = (d & bm) | (old & ~bm);
            end
        end
        return p;
    endfunction

    // Transaction tracking at the clock edge.
    always @(posedge CLK) begin
        if (RESET) begin
            busy    <= 1'b0;
            started <= 1'b1;
            for (int i = 0; i < 64; i++) model_mem[i] <= preload[i];
        end else if (busy) begin
            if (resp_valid && resp_ready) begin
                busy <= 1'b0;
                if (ex.wr_cyc != 0) model_mem[ex.addr[8:3]] <= ex.wdata;
            end else begin
                cyc <= cyc + 1;
            end
        end else if (req_valid && req_ready) begin
            ex   <= predict(req_bits, exc_plan);
            busy <= 1'b1;
            cyc  <= 1;
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge CLK) begin
        if (started) begin
            bit rd_e;
            bit wr_e;
            rd_e = busy && ex.rd && (cyc == 1);
            wr_e = busy && (ex.wr_cyc != 0) && (cyc == ex.wr_cyc);
            chk("req_ready", {63'h0, req_ready}, {63'h0, !busy});
            chk("resp_valid", {63'h0, resp_valid}, {63'h0, busy && (cyc >= ex.lat)});
            chk("ram_rden", {63'h0, ram_rden}, {63'h0, rd_e});
            chk("ram_wren", {63'h0, ram_wren}, {63'h0, wr_e});
            chk("ram_addr", ram_addr, (rd_e || wr_e) ? ex.addr : 64'h0);
            chk("ram_wdata", ram_wdata, wr_e ? ex.wdata : 64'h0);
            if (busy && (cyc >= ex.lat)) begin
                chk("resp_data", resp_data, ex.data);
                chk("resp_err", {63'h0, resp_err}, {63'h0, ex.err});
            end
        end
    end

    task automatic run_txn(input logic w, input logic [7:0] m, input logic [63:0] a, input logic [63:0] d,
                           input bit exc, input int dly,
                           output logic [63:0] gd, output logic ge, output int gl);
        int k;
        gd = 64'h0; ge = 1'b0; gl = 0;
        @(negedge CLK);
        k = 0;
        while (!req_ready && k < 50) begin @(negedge CLK); k++; end
        exc_plan  = exc;
        req_bits  = {w, m, a, d};
        req_valid = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        k = 1;
        while (!resp_valid && k < 40) begin @(negedge CLK); k++; end
        if (!resp_valid) begin
            chk("resp_timeout", 64'h0, 64'h1);
        end else begin
            gl = k; gd = resp_data; ge = resp_err;
            repeat (dly) @(negedge CLK);
            resp_ready = 1'b1;
            @(negedge CLK);
            resp_ready = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] gd;
        logic        ge;
        int          gl;
        int          rd0;
        int          wr0;
        RESET = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_bits = '0;
        for (int i = 0; i < 64; i++) preload[i] = {$urandom, $urandom};
        preload[32] = 64'h1122334455667788;
        preload[5]  = 64'h1111111122222222;
        repeat (3) @(negedge CLK);
        chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
        chk("rst_ram_addr", ram_addr, 64'h0);
        chk("rst_ram_wdata", ram_wdata, 64'h0);
        RESET = 1'b0;

        rd0 = rd_cnt; wr0 = wr_cnt;
        run_txn(1'b0, 8'h00, 64'h100, 64'h0, 1'b0, 0, gd, ge, gl);
        chk("load_lat", 64'(gl), 64'd3);
        chk("load_data", gd, 64'h1122334455667788);
        chk("load_err", {63'h0, ge}, 64'h0);
        chk("load_rd_cnt", 64'(rd_cnt - rd0), 64'd1);

        wr0 = wr_cnt;
        run_txn(1'b1, 8'h0F, 64'h28, 64'hAAAAAAAABBBBBBBB, 1'b0, 0, gd, ge, gl);
        chk("pst_lat", 64'(gl), 64'd4);
        chk("pst_data", gd, 64'h1111111122222222);
        chk("pst_wr_cnt", 64'(wr_cnt - wr0), 64'd1);
        chk("pst_ram_word", ram_mem[5], 64'h11111111BBBBBBBB);

        rd0 = rd_cnt; wr0 = wr_cnt;
        run_txn(1'b1, 8'hFF, 64'h8, 64'hDEADBEEFCAFEF00D, 1'b0, 0, gd, ge, gl);
        chk("fst_lat", 64'(gl), 64'd2);
        chk("fst_data", gd, 64'h0);
        chk("fst_rd_cnt", 64'(rd_cnt - rd0), 64'd0);
        chk("fst_wr_cnt", 64'(wr_cnt - wr0), 64'd1);
        chk("fst_ram_word", ram_mem[1], 64'hDEADBEEFCAFEF00D);

        rd0 = rd_cnt; wr0 = wr_cnt;
        run_txn(1'b1, 8'hFF, 64'h9, 64'h1234, 1'b0, 0, gd, ge, gl);
        chk("mis_lat", 64'(gl), 64'd1);
        chk("mis_err", {63'h0, ge}, 64'h1);
        chk("mis_ram_cnt", 64'(rd_cnt - rd0 + wr_cnt - wr0), 64'd0);

        run_txn(1'b1, 8'h00, 64'h10, 64'h1234, 1'b0, 0, gd, ge, gl);
        chk("empty_lat", 64'(gl), 64'd1);
        chk("empty_err", {63'h0, ge}, 64'h0);

        wr0 = wr_cnt;
        run_txn(1'b1, 8'h3C, 64'h40, 64'h5A5A5A5A5A5A5A5A, 1'b1, 0, gd, ge, gl);
        chk("exc_lat", 64'(gl), 64'd3);
        chk("exc_err", {63'h0, ge}, 64'h1);
        chk("exc_data", gd, 64'h0);
        chk("exc_wr_cnt", 64'(wr_cnt - wr0), 64'd0);

        run_txn(1'b0, 8'h00, 64'h100, 64'h0, 1'b0, 5, gd, ge, gl);
        chk("bp_data", gd, 64'h1122334455667788);

        // Reset while the bridge sits in READ: request dropped, no write.
        @(negedge CLK);
        wr0 = wr_cnt;
        exc_plan = 1'b0;
        req_bits = {1'b1, 8'h0F, 64'h28, 64'h5555555555555555};
        req_valid = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("rr_rden", {63'h0, ram_rden}, 64'h1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("rr_req_ready", {63'h0, req_ready}, 64'h1);
        chk("rr_resp_valid", {63'h0, resp_valid}, 64'h0);
        run_txn(1'b0, 8'h00, 64'h100, 64'h0, 1'b0, 0, gd, ge, gl);
        chk("rr_load_data", gd, 64'h1122334455667788);
        chk("rr_wr_cnt", 64'(wr_cnt - wr0), 64'd0);

        for (int t = 0; t < 200; t++) begin
            logic [7:0]  m;
            logic [63:0] a;
            int          sel;
            sel = $urandom_range(0, 3);
            m = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            a = {55'h0, 6'($urandom), 3'b000};
            if ($urandom_range(0, 4) == 0) a[2:0] = 3'($urandom_range(1, 7));
            run_txn(1'($urandom), m, a, {$urandom, $urandom}, ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 3), gd, ge, gl);
        end

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
